// File: rtl/frame_buffer_if.sv
// -----------------------------------------------------------------------------
// frame_buffer_if
//
// Bundles the render-side write port, the scan-out read port, the clear
// sequencer control and the bank-swap control of frame_buffer.
//
//   master : the client side (renderer, scan-out, test driver)
//   slave  : the frame buffer itself
//
// Signals
//   write_enable              write request, qualifies data_in / data_in_x/y
//   data_in [PIX_W]           pixel to write, channel 0 in the LSBs
//   data_in_x, data_in_y      write coordinates (11 bits each)
//   read_enable               read request
//   data_out_x, data_out_y    read coordinates (11 bits each)
//   data_out [PIX_W]          read data, 2 cycles after the request
//   data_out_valid            one-cycle strobe per completed read
//   clear_start               pulse: fill the write-side bank with CLEAR_VALUE
//   clear_busy                clear sequencer active
//   wr_range_err              sticky flag: an out-of-range write was dropped
//   swap_req                  request a front/back bank swap
//   front_bank                bank currently served to reads
// -----------------------------------------------------------------------------
interface frame_buffer_if #(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 3
);
    localparam int PIX_W = DATA_W * CHANNELS;

    logic             write_enable;
    logic [PIX_W-1:0] data_in;
    logic [10:0]      data_in_x;
    logic [10:0]      data_in_y;
    logic             read_enable;
    logic [10:0]      data_out_x;
    logic [10:0]      data_out_y;
    logic [PIX_W-1:0] data_out;
    logic             data_out_valid;
    logic             clear_start;
    logic             clear_busy;
    logic             wr_range_err;
    logic             swap_req;
    logic             front_bank;

    modport master (
        output write_enable, data_in, data_in_x, data_in_y,
        output read_enable, data_out_x, data_out_y,
        output clear_start, swap_req,
        input  data_out, data_out_valid, clear_busy, wr_range_err, front_bank
    );

    modport slave (
        input  write_enable, data_in, data_in_x, data_in_y,
        input  read_enable, data_out_x, data_out_y,
        input  clear_start, swap_req,
        output data_out, data_out_valid, clear_busy, wr_range_err, front_bank
    );
endinterface

// File: rtl/frame_buffer.sv
// -----------------------------------------------------------------------------
// frame_buffer
//
// Multi-channel frame store of WIDTH x HEIGHT pixels, each CHANNELS x DATA_W
// bits (channel 0 in the LSBs). The render side writes by (x, y), the VGA
// scan-out side reads by (x, y), both on CLOCK_50.
//
// Ports
//   CLOCK_50   system clock, all logic on the rising edge
//   reset_n    asynchronous active-low reset (memory contents are kept)
//   bus        frame_buffer_if.slave: write port, read port, clear control,
//              range error flag, bank swap control
//
// Behaviour summary
//   - Write: coordinates/data captured at edge N (linear address computed and
//     registered), memory written at edge N+1. Out-of-range writes are
//     dropped and set the sticky wr_range_err at N+1.
//   - Read: address registered at edge N, memory read at N+1, data_out and
//     data_out_valid at N+2. Out-of-range reads complete with data 0.
//     Memory is read-first, so a write sampled at N is not seen by a read
//     sampled at N, but is seen by a read sampled at N+1.
//   - Clear: clear_start in IDLE fills every address of the write-side bank
//     with CLEAR_VALUE, one address per cycle, WIDTH*HEIGHT cycles in total.
//     Normal writes and further clear_start pulses are ignored meanwhile.
//
// Build option
//   DOUBLE_BUFFER_EN  when defined, two banks: reads use front_bank, writes
//                     and clear use the other bank; swap_req toggles
//                     front_bank once the buffer is idle with no write in the
//                     address stage. When undefined, a single bank is used,
//                     swap_req is ignored and front_bank is 0.
// -----------------------------------------------------------------------------
module frame_buffer #(
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int DATA_W      = 8,
    parameter int CHANNELS    = 3,
    parameter int CLEAR_VALUE = 0
) (
    input  logic          CLOCK_50,
    input  logic          reset_n,
    frame_buffer_if.slave bus
);

    localparam int PIX_W = DATA_W * CHANNELS;
    localparam int DEPTH = WIDTH * HEIGHT;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef DOUBLE_BUFFER_EN
    localparam int NBANKS = 2;
`else
    localparam int NBANKS = 1;
`endif
    localparam logic [DATA_W-1:0] CLEAR_CH  = DATA_W'(CLEAR_VALUE);
    localparam logic [PIX_W-1:0]  CLEAR_PIX = {CHANNELS{CLEAR_CH}};
    localparam logic [AW-1:0]     LAST_ADDR = AW'(DEPTH - 1);

    // Coordinates are 11 bits wide; widen before comparing with the
    // integer frame dimensions so no bits are lost.
    function automatic logic coord_in_range(input logic [10:0] x,
                                            input logic [10:0] y);
        return ({21'd0, x} < 32'(WIDTH)) && ({21'd0, y} < 32'(HEIGHT));
    endfunction

    // Row-major linear address. Only meaningful for in-range coordinates.
    function automatic logic [AW-1:0] linear_addr(input logic [10:0] x,
                                                  input logic [10:0] y);
        return AW'({21'd0, y} * 32'(WIDTH) + {21'd0, x});
    endfunction

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [AW-1:0]   clr_cnt_q;
    logic [AW-1:0]   clr_cnt_d;

    logic            front_bank_q;
    logic            back_bank;

    // Write address stage
    logic            wr_vld_p0;
    logic            wr_oor_p0;
    logic [AW-1:0]   wr_addr_p0;
    logic [PIX_W-1:0] wr_data_p0;
    logic            wr_bank_p0;
    logic            wr_accept;
    logic            wr_err_q;

    // Read pipeline
    logic            rd_vld_p0;
    logic            rd_oor_p0;
    logic [AW-1:0]   rd_addr_p0;
    logic            rd_bank_p0;
    logic            rd_vld_p1;
    logic            rd_oor_p1;
    logic [PIX_W-1:0] rd_data_p1;
    logic            rd_vld_p2;
    logic [PIX_W-1:0] rd_data_p2;

    // Single memory write port, shared by normal writes and the clear
    logic            mem_we;
    logic            mem_wbank;
    logic [AW-1:0]   mem_waddr;
    logic [PIX_W-1:0] mem_wdata;

    logic [PIX_W-1:0] mem [NBANKS][DEPTH];

    // A write coinciding with clear_start loses to the clear, and the
    // write port is closed for the whole clear.
    assign wr_accept = bus.write_enable && (state_q == IDLE) && !bus.clear_start;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        mem_we    = 1'b0;
        mem_wbank = wr_bank_p0;
        mem_waddr = wr_addr_p0;
        mem_wdata = wr_data_p0;
        unique case (state_q)
            IDLE: begin
                mem_we = wr_vld_p0;
                if (bus.clear_start) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            CLEAR: begin
                // No normal write can be pending here: the cycle that
                // entered CLEAR refused the write port.
                mem_we    = 1'b1;
                mem_wbank = back_bank;
                mem_waddr = clr_cnt_q;
                mem_wdata = CLEAR_PIX;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------- bank select
`ifdef DOUBLE_BUFFER_EN
    logic swap_pend_q;

    // A swap waits until the clear is finished and no write is about to
    // land, so a write always hits the bank it was issued against.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            front_bank_q <= 1'b0;
            swap_pend_q  <= 1'b0;
        end else if ((bus.swap_req || swap_pend_q) && (state_q == IDLE) && !wr_vld_p0) begin
            front_bank_q <= ~front_bank_q;
            swap_pend_q  <= 1'b0;
        end else if (bus.swap_req) begin
            swap_pend_q  <= 1'b1;
        end
    end

    assign back_bank = ~front_bank_q;
`else
    logic unused_swap_req;

    assign front_bank_q    = 1'b0;
    assign back_bank       = 1'b0;
    assign unused_swap_req = bus.swap_req;
`endif

    // ------------------------------------------------ stage p0: addresses
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            wr_vld_p0 <= 1'b0;
            wr_oor_p0 <= 1'b0;
            rd_vld_p0 <= 1'b0;
            rd_oor_p0 <= 1'b0;
        end else begin
            wr_vld_p0 <= wr_accept && coord_in_range(bus.data_in_x, bus.data_in_y);
            wr_oor_p0 <= wr_accept && !coord_in_range(bus.data_in_x, bus.data_in_y);
            rd_vld_p0 <= bus.read_enable;
            rd_oor_p0 <= !coord_in_range(bus.data_out_x, bus.data_out_y);
        end
    end

    // Out-of-range reads are parked on address 0 so the memory is never
    // indexed past its depth; their data is discarded at the output.
    always_ff @(posedge CLOCK_50) begin
        wr_addr_p0 <= linear_addr(bus.data_in_x, bus.data_in_y);
        wr_data_p0 <= bus.data_in;
        wr_bank_p0 <= back_bank;
        rd_addr_p0 <= coord_in_range(bus.data_out_x, bus.data_out_y)
                      ? linear_addr(bus.data_out_x, bus.data_out_y) : '0;
        rd_bank_p0 <= front_bank_q;
    end

    // -------------------------------------------- stage p1: memory access
    // Read-first: the read samples the array before this edge's write.
    always_ff @(posedge CLOCK_50) begin
        if (mem_we) begin
            mem[mem_wbank][mem_waddr] <= mem_wdata;
        end
        if (rd_vld_p0) begin
            rd_data_p1 <= mem[rd_bank_p0][rd_addr_p0];
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            rd_vld_p1 <= 1'b0;
            rd_oor_p1 <= 1'b0;
            wr_err_q  <= 1'b0;
        end else begin
            rd_vld_p1 <= rd_vld_p0;
            rd_oor_p1 <= rd_oor_p0;
            if (wr_oor_p0) begin
                wr_err_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------ stage p2: read data
    // data_out holds the last completed read while no read completes.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            rd_vld_p2  <= 1'b0;
            rd_data_p2 <= '0;
        end else begin
            rd_vld_p2 <= rd_vld_p1;
            if (rd_vld_p1) begin
                rd_data_p2 <= rd_oor_p1 ? '0 : rd_data_p1;
            end
        end
    end

    assign bus.data_out       = rd_data_p2;
    assign bus.data_out_valid = rd_vld_p2;
    assign bus.clear_busy     = (state_q == CLEAR);
    assign bus.wr_range_err   = wr_err_q;
    assign bus.front_bank     = front_bank_q;

endmodule

// File: tb/tb_frame_buffer.sv
module tb_frame_buffer;

    localparam int BW = 640;
    localparam int BH = 480;
    localparam int SW = 8;
    localparam int SH = 4;
    localparam int NR = 300;
    localparam logic [23:0] CLR_PIX = 24'h0F0F0F;

    logic CLOCK_50;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    frame_buffer_if #(.DATA_W(8), .CHANNELS(3)) bus_big ();
    frame_buffer_if #(.DATA_W(8), .CHANNELS(3)) bus_sml ();

    frame_buffer #(.WIDTH(BW), .HEIGHT(BH), .DATA_W(8), .CHANNELS(3), .CLEAR_VALUE(0))
        u_big (.CLOCK_50(CLOCK_50), .reset_n(reset_n), .bus(bus_big));

    frame_buffer #(.WIDTH(SW), .HEIGHT(SH), .DATA_W(8), .CHANNELS(3), .CLEAR_VALUE(15))
        u_sml (.CLOCK_50(CLOCK_50), .reset_n(reset_n), .bus(bus_sml));

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic idle_big();
        bus_big.write_enable = 1'b0;
        bus_big.read_enable  = 1'b0;
        bus_big.clear_start  = 1'b0;
        bus_big.swap_req     = 1'b0;
        bus_big.data_in      = '0;
        bus_big.data_in_x    = '0;
        bus_big.data_in_y    = '0;
        bus_big.data_out_x   = '0;
        bus_big.data_out_y   = '0;
    endtask

    task automatic idle_sml();
        bus_sml.write_enable = 1'b0;
        bus_sml.read_enable  = 1'b0;
        bus_sml.clear_start  = 1'b0;
        bus_sml.swap_req     = 1'b0;
        bus_sml.data_in      = '0;
        bus_sml.data_in_x    = '0;
        bus_sml.data_in_y    = '0;
        bus_sml.data_out_x   = '0;
        bus_sml.data_out_y   = '0;
    endtask

    task automatic set_wr_big(input int x, input int y, input logic [23:0] d);
        bus_big.write_enable = 1'b1;
        bus_big.data_in_x    = 11'(x);
        bus_big.data_in_y    = 11'(y);
        bus_big.data_in      = d;
    endtask

    task automatic set_rd_big(input int x, input int y);
        bus_big.read_enable = 1'b1;
        bus_big.data_out_x  = 11'(x);
        bus_big.data_out_y  = 11'(y);
    endtask

    task automatic set_wr_sml(input int x, input int y, input logic [23:0] d);
        bus_sml.write_enable = 1'b1;
        bus_sml.data_in_x    = 11'(x);
        bus_sml.data_in_y    = 11'(y);
        bus_sml.data_in      = d;
    endtask

    task automatic set_rd_sml(input int x, input int y);
        bus_sml.read_enable = 1'b1;
        bus_sml.data_out_x  = 11'(x);
        bus_sml.data_out_y  = 11'(y);
    endtask

    task automatic test_reset();
        idle_big();
        idle_sml();
        reset_n = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        checks++; if (bus_big.data_out !== 24'h0) begin errors++; $display("FAIL reset_data_out: got %h want 000000", bus_big.data_out); end
        checks++; if (bus_big.data_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus_big.data_out_valid); end
        checks++; if (bus_big.clear_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus_big.clear_busy); end
        checks++; if (bus_big.wr_range_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus_big.wr_range_err); end
        checks++; if (bus_big.front_bank !== 1'b0) begin errors++; $display("FAIL reset_front: got %b want 0", bus_big.front_bank); end
        checks++; if (bus_sml.clear_busy !== 1'b0) begin errors++; $display("FAIL reset_sml_busy: got %b want 0", bus_sml.clear_busy); end
        reset_n = 1'b1;
        tick();
        tick();
        checks++; if (bus_big.data_out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b want 0", bus_big.data_out_valid); end
        checks++; if (bus_sml.clear_busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b want 0", bus_sml.clear_busy); end
    endtask

    task automatic test_write_read();
        set_wr_big(10, 20, 24'h112233);
        tick();
        idle_big();
        tick();
        set_rd_big(10, 20);
        tick();
        idle_big();
        checks++; if (bus_big.data_out_valid !== 1'b0) begin errors++; $display("FAIL wr_rd_lat0: valid got %b want 0", bus_big.data_out_valid); end
        tick();
        checks++; if (bus_big.data_out_valid !== 1'b0) begin errors++; $display("FAIL wr_rd_lat1: valid got %b want 0", bus_big.data_out_valid); end
        tick();
        checks++; if (bus_big.data_out_valid !== 1'b1) begin errors++; $display("FAIL wr_rd_lat2: valid got %b want 1", bus_big.data_out_valid); end
        checks++; if (bus_big.data_out !== 24'h112233) begin errors++; $display("FAIL wr_rd_data: got %h want 112233", bus_big.data_out); end
        tick();
        checks++; if (bus_big.data_out_valid !== 1'b0) begin errors++; $display("FAIL wr_rd_one_cycle: valid got %b want 0", bus_big.data_out_valid); end
        checks++; if (bus_big.data_out !== 24'h112233) begin errors++; $display("FAIL wr_rd_hold: got %h want 112233", bus_big.data_out); end
    endtask

    task automatic test_out_of_range();
        set_wr_big(639, 0, 24'h445566);
        tick();
        set_wr_big(0, 1, 24'h010203);
        tick();
        set_wr_big(640, 0, 24'hFFFFFF);
        tick();
        idle_big();
        checks++; if (bus_big.wr_range_err !== 1'b0) begin errors++; $display("FAIL oor_err_early: got %b want 0", bus_big.wr_range_err); end
        tick();
        checks++; if (bus_big.wr_range_err !== 1'b1) begin errors++; $display("FAIL oor_err_set: got %b want 1", bus_big.wr_range_err); end
        set_rd_big(639, 0);
        tick();
        set_rd_big(0, 480);
        tick();
        set_rd_big(0, 1);
        tick();
        idle_big();
        checks++; if (bus_big.data_out !== 24'h445566) begin errors++; $display("FAIL oor_neighbour: got %h want 445566", bus_big.data_out); end
        tick();
        checks++; if (bus_big.data_out_valid !== 1'b1) begin errors++; $display("FAIL oor_rd_valid: got %b want 1", bus_big.data_out_valid); end
        checks++; if (bus_big.data_out !== 24'h000000) begin errors++; $display("FAIL oor_rd_zero: got %h want 000000", bus_big.data_out); end
        tick();
        checks++; if (bus_big.data_out !== 24'h010203) begin errors++; $display("FAIL oor_no_alias: got %h want 010203", bus_big.data_out); end
        repeat (3) tick();
        checks++; if (bus_big.wr_range_err !== 1'b1) begin errors++; $display("FAIL oor_err_sticky: got %b want 1", bus_big.wr_range_err); end
    endtask

    task automatic test_read_first();
        set_wr_big(5, 5, 24'h0000AA);
        tick();
        idle_big();
        tick();
        set_wr_big(5, 5, 24'h0000BB);
        set_rd_big(5, 5);
        tick();
        idle_big();
        set_rd_big(5, 5);
        tick();
        idle_big();
        tick();
        checks++; if (bus_big.data_out !== 24'h0000AA || bus_big.data_out_valid !== 1'b1) begin errors++; $display("FAIL read_first_old: got %h/%b want 0000aa/1", bus_big.data_out, bus_big.data_out_valid); end
        tick();
        checks++; if (bus_big.data_out !== 24'h0000BB || bus_big.data_out_valid !== 1'b1) begin errors++; $display("FAIL read_first_new: got %h/%b want 0000bb/1", bus_big.data_out, bus_big.data_out_valid); end
    endtask

    task automatic test_clear();
        int cnt;
        for (int i = 0; i < SW * SH; i++) begin
            set_wr_sml(i % SW, i / SW, 24'h800000 | 24'(i));
            tick();
        end
        idle_sml();
        // write coinciding with clear_start is dropped; out-of-range so it would flag
        bus_sml.clear_start = 1'b1;
        set_wr_sml(9, 9, 24'h777777);
        tick();
        idle_sml();
        checks++; if (bus_sml.clear_busy !== 1'b1) begin errors++; $display("FAIL clear_busy_rise: got %b want 1", bus_sml.clear_busy); end
        cnt = 1;
        for (int k = 1; k < 100; k++) begin
            if (k == 10) bus_sml.clear_start = 1'b1;
            if (k == 20) set_wr_sml(2, 0, 24'hABCDEF);
            if (k == 21) set_wr_sml(12, 0, 24'hABCDEF);
            tick();
            idle_sml();
            if (bus_sml.clear_busy) cnt++;
            else break;
        end
        checks++; if (cnt !== SW * SH) begin errors++; $display("FAIL clear_busy_cycles: got %0d want %0d", cnt, SW * SH); end
        checks++; if (bus_sml.wr_range_err !== 1'b0) begin errors++; $display("FAIL clear_no_err: got %b want 0", bus_sml.wr_range_err); end
        for (int i = 0; i < SW * SH + 2; i++) begin
            if (i < SW * SH) set_rd_sml(i % SW, i / SW);
            else idle_sml();
            tick();
            if (i >= 2) begin
                checks++;
                if (bus_sml.data_out_valid !== 1'b1 || bus_sml.data_out !== CLR_PIX) begin
                    errors++;
                    $display("FAIL clear_pixel_%0d: got %h/%b want %h/1", i - 2, bus_sml.data_out, bus_sml.data_out_valid, CLR_PIX);
                end
            end
        end
        idle_sml();
    endtask

    task automatic test_reset_mid_clear();
        logic [23:0] want;
        for (int i = 0; i < SW * SH; i++) begin
            set_wr_sml(i % SW, i / SW, 24'h5A5A00 | 24'(i));
            tick();
        end
        idle_sml();
        bus_sml.clear_start = 1'b1;
        tick();
        idle_sml();
        repeat (10) tick();
        reset_n = 1'b0;
        #1;
        checks++; if (bus_sml.clear_busy !== 1'b0) begin errors++; $display("FAIL midclr_busy: got %b want 0", bus_sml.clear_busy); end
        checks++; if (bus_sml.data_out !== 24'h0) begin errors++; $display("FAIL midclr_data: got %h want 000000", bus_sml.data_out); end
        checks++; if (bus_sml.data_out_valid !== 1'b0) begin errors++; $display("FAIL midclr_valid: got %b want 0", bus_sml.data_out_valid); end
        checks++; if (bus_sml.wr_range_err !== 1'b0) begin errors++; $display("FAIL midclr_err: got %b want 0", bus_sml.wr_range_err); end
        checks++; if (bus_big.wr_range_err !== 1'b0) begin errors++; $display("FAIL midclr_big_err: got %b want 0", bus_big.wr_range_err); end
        checks++; if (bus_big.data_out !== 24'h0) begin errors++; $display("FAIL midclr_big_data: got %h want 000000", bus_big.data_out); end
        tick();
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < SW * SH + 2; i++) begin
            if (i < SW * SH) set_rd_sml(i % SW, i / SW);
            else idle_sml();
            tick();
            if (i >= 2) begin
                want = (i - 2 < 10) ? CLR_PIX : (24'h5A5A00 | 24'(i - 2));
                checks++;
                if (bus_sml.data_out_valid !== 1'b1 || bus_sml.data_out !== want) begin
                    errors++;
                    $display("FAIL midclr_pixel_%0d: got %h/%b want %h/1", i - 2, bus_sml.data_out, bus_sml.data_out_valid, want);
                end
            end
        end
        idle_sml();
    endtask

    task automatic test_random();
        logic [23:0] mdl [int];
        bit          hv [0:NR+1];
        bit          hk [0:NR+1];
        logic [23:0] hd [0:NR+1];
        bit          exp_err;
        int          wbank;
        int          rbank;
`ifdef DOUBLE_BUFFER_EN
        wbank = 1;
        rbank = 0;
`else
        wbank = 0;
        rbank = 0;
`endif
        exp_err = bus_big.wr_range_err;
        for (int i = 0; i < NR + 2; i++) begin
            bit          we;
            bit          re;
            bit          err_before;
            int          wx, wy, rx, ry;
            logic [23:0] d;
            idle_big();
            we = 1'b0;
            re = 1'b0;
            wx = 0; wy = 0; rx = 0; ry = 0; d = '0;
            if (i < NR) begin
                we = 1'($urandom_range(0, 1));
                re = 1'($urandom_range(0, 1));
                wx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(640, 2047)) : int'($urandom_range(0, 15));
                wy = ($urandom_range(0, 9) == 0) ? int'($urandom_range(480, 2047)) : int'($urandom_range(0, 7));
                rx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(640, 2047)) : int'($urandom_range(0, 15));
                ry = ($urandom_range(0, 9) == 0) ? int'($urandom_range(480, 2047)) : int'($urandom_range(0, 7));
                d  = 24'($urandom);
                if (we) set_wr_big(wx, wy, d);
                if (re) set_rd_big(rx, ry);
            end
            // a read sees every write issued in earlier cycles, not this one
            hv[i] = re;
            hk[i] = 1'b0;
            hd[i] = '0;
            if (re) begin
                if (rx >= BW || ry >= BH) begin
                    hk[i] = 1'b1;
                end else if (mdl.exists(rbank * BW * BH + ry * BW + rx)) begin
                    hk[i] = 1'b1;
                    hd[i] = mdl[rbank * BW * BH + ry * BW + rx];
                end
            end
            err_before = exp_err;
            if (we) begin
                if (wx >= BW || wy >= BH) exp_err = 1'b1;
                else mdl[wbank * BW * BH + wy * BW + wx] = d;
            end
            tick();
            checks++;
            if (bus_big.wr_range_err !== err_before) begin
                errors++;
                $display("FAIL rand_err_cyc%0d: got %b want %b", i, bus_big.wr_range_err, err_before);
            end
            if (i >= 2) begin
                checks++;
                if (bus_big.data_out_valid !== hv[i-2]) begin
                    errors++;
                    $display("FAIL rand_valid_cyc%0d: got %b want %b", i, bus_big.data_out_valid, hv[i-2]);
                end
                if (hv[i-2] && hk[i-2]) begin
                    checks++;
                    if (bus_big.data_out !== hd[i-2]) begin
                        errors++;
                        $display("FAIL rand_data_cyc%0d: got %h want %h", i, bus_big.data_out, hd[i-2]);
                    end
                end
            end
        end
        idle_big();
    endtask

`ifdef DOUBLE_BUFFER_EN
    task automatic test_double_buffer();
        logic fb;
        int   guard;
        fb = bus_big.front_bank;
        set_wr_big(1, 1, 24'h123456);
        tick();
        idle_big();
        tick();
        bus_big.swap_req = 1'b1;
        tick();
        idle_big();
        checks++; if (bus_big.front_bank !== ~fb) begin errors++; $display("FAIL swap_toggle: got %b want %b", bus_big.front_bank, ~fb); end
        set_rd_big(1, 1);
        tick();
        idle_big();
        tick();
        tick();
        checks++; if (bus_big.data_out !== 24'h123456 || bus_big.data_out_valid !== 1'b1) begin errors++; $display("FAIL swap_read: got %h/%b want 123456/1", bus_big.data_out, bus_big.data_out_valid); end
        fb = bus_sml.front_bank;
        bus_sml.clear_start = 1'b1;
        tick();
        idle_sml();
        bus_sml.swap_req = 1'b1;
        tick();
        idle_sml();
        guard = 0;
        while (bus_sml.clear_busy === 1'b1 && guard < 100) begin
            checks++; if (bus_sml.front_bank !== fb) begin errors++; $display("FAIL swap_during_clear: got %b want %b", bus_sml.front_bank, fb); end
            tick();
            guard++;
        end
        checks++; if (bus_sml.clear_busy !== 1'b0 || bus_sml.front_bank !== fb) begin errors++; $display("FAIL swap_at_fall: busy/front got %b/%b want 0/%b", bus_sml.clear_busy, bus_sml.front_bank, fb); end
        tick();
        checks++; if (bus_sml.front_bank !== ~fb) begin errors++; $display("FAIL swap_after_clear: got %b want %b", bus_sml.front_bank, ~fb); end
    endtask
`else
    task automatic test_swap_ignored();
        bus_big.swap_req = 1'b1;
        bus_sml.swap_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (bus_big.front_bank !== 1'b0 || bus_sml.front_bank !== 1'b0) begin
                errors++;
                $display("FAIL swap_ignored_%0d: got %b/%b want 0/0", k, bus_big.front_bank, bus_sml.front_bank);
            end
        end
        idle_big();
        idle_sml();
    endtask
`endif

    initial begin
        test_reset();
`ifdef DOUBLE_BUFFER_EN
        test_random();
        test_double_buffer();
`else
        test_write_read();
        test_out_of_range();
        test_read_first();
        test_clear();
        test_reset_mid_clear();
        test_random();
        test_swap_ignored();
`endif
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
